icetap_read_ctrl: RTL and testbench
===================================

// Module: icetap_read_ctrl
// PURPOSE
//  Sequences the readout of the icetap capture RAM after a recording completes. Converts
//  read_req_first/read_req_next pulses (already in src_clk domain) into RAM read cycles in
//  chronological order, oldest sample first, and holds each sample for the scan serializer.
//  Sits between the recorder (RAM, status addresses) and the scan data-shift logic.
// PARAMETERS
//  NR_SIGNALS    16   sample width, bits
//  RECORD_DEPTH  256  RAM entries; power of two; RAM_ADDR_BITS = $clog2(RECORD_DEPTH)
//  RAM_LATENCY   1    cycles from ram_rd_en to valid ram_rd_data (1..3)
// PORTS
//  src_clk         in   1              single clock
//  src_reset       in   1              synchronous, active-high reset
//  state           in   2              recorder state: 0 IDLE, 1 ARMED, 2 TRIGGERED, 3 DONE
//  wrapped         in   1              buffer wrapped during the recording
//  start_addr      in   RAM_ADDR_BITS  first written address
//  trigger_addr    in   RAM_ADDR_BITS  address of trigger sample
//  stop_addr       in   RAM_ADDR_BITS  last written address
//  read_req_first  in   1              pulse: (re)start readout at oldest sample
//  read_req_next   in   1              pulse: advance to next sample
//  ram_rd_en       out  1              RAM read strobe
//  ram_rd_addr     out  RAM_ADDR_BITS  RAM read address
//  ram_rd_data     in   NR_SIGNALS     RAM read data
//  read_data       out  NR_SIGNALS     held sample
//  read_valid      out  1              read_data valid
//  read_last       out  1              read_data is the stop_addr sample
//  read_done       out  1              1-cycle pulse: last sample consumed
//  read_err        out  1              1-cycle pulse: request rejected or readout aborted
//  read_idx        out  RAM_ADDR_BITS  index of held sample, 0 = oldest
// BEHAVIOUR
//  - Reset: FSM IDLE; all outputs 0; addr and read_idx 0. Reset mid-readout: abort silently (no err).
//  - FSM states IDLE, ISSUE, WAIT, HOLD.
//  - IDLE: read_req_first && state==3 -> addr=first_addr, read_idx=0, go ISSUE.
//    read_req_first && state!=3 -> read_err pulse, stay. read_req_next ignored.
//  - first_addr = wrapped ? stop_addr+1 (mod RECORD_DEPTH) : start_addr.
//  - ISSUE (1 cycle): ram_rd_en=1, ram_rd_addr=addr; go WAIT. ram_rd_en is 0 in all other states.
//  - WAIT (RAM_LATENCY cycles, down-counter): on last cycle capture ram_rd_data into read_data,
//    set read_valid, set read_last=(addr==stop_addr); go HOLD.
//  - Latency: request at cycle T -> ram_rd_en at T+1 -> read_valid first high at T+2+RAM_LATENCY.
//  - HOLD: read_valid=1, read_data stable until next request.
//    read_req_next && !read_last -> addr+1 (wraps RECORD_DEPTH-1 -> 0), read_idx+1, read_valid=0, go ISSUE.
//    read_req_next && read_last -> read_done pulse, read_valid=0, read_last=0, go IDLE.
//  - read_req_first in ISSUE/WAIT/HOLD: restart from first_addr (priority over read_req_next
//    in the same cycle); read_valid drops next cycle. read_req_next outside HOLD: ignored.
//  - state leaving 3 while not IDLE (new capture started): abort -> read_err pulse, read_valid=0, go IDLE.
//  - Single-sample capture (first_addr==stop_addr): read_last=1 with the first sample.
//  - Full wrapped buffer: RECORD_DEPTH samples, read_idx 0..RECORD_DEPTH-1, no idx overflow.
// CONFIGURATION
//  ICETAP_READ_TRIG_MARK_EN defined: extra output read_is_trig (1 bit), set with read_valid
//    when the held sample's addr==trigger_addr, cleared with read_valid; reset 0.
//  Not defined: port absent, no compare logic; all other behaviour identical.
// TESTING
//  - Not wrapped, start=0x10, stop=0x13, state=3: first + 3x next -> addrs 0x10..0x13, last on 0x13, done on 4th next.
//  - Wrapped, stop=0xFE, DEPTH=256: first -> ram_rd_addr=0xFF, next -> 0x00; 256 samples, read_idx 0..255, read_last only at 0xFE.
//  - RAM_LATENCY=2: read_req_first at T -> ram_rd_en at T+1, read_valid at T+4, read_data = RAM word.
//  - state=1, read_req_first -> read_err 1 cycle, no ram_rd_en; state drops 3->0 in HOLD -> read_err, read_valid=0, IDLE.
//  - read_req_first and read_req_next same cycle in HOLD -> restart at first_addr, read_idx=0.
//  - TRIG_MARK_EN, trigger_addr=0x12, start=0x10: read_is_trig high only on 3rd sample; src_reset mid-WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/icetap_read_ctrl.sv
// icetap capture-RAM readout sequencer: walks the RAM oldest-first and holds each sample for the scan shifter.
// Optional build macro ICETAP_READ_TRIG_MARK_EN adds read_is_trig (held sample is the trigger sample).
module icetap_read_ctrl #(
  parameter int NR_SIGNALS   = 16,
  parameter int RECORD_DEPTH = 256,
  parameter int RAM_LATENCY  = 1,
  localparam int RAM_ADDR_BITS = $clog2(RECORD_DEPTH)
) (
  input  logic                     src_clk,
  input  logic                     src_reset,
  input  logic [1:0]               state,
  input  logic                     wrapped,
  input  logic [RAM_ADDR_BITS-1:0] start_addr,
  input  logic [RAM_ADDR_BITS-1:0] trigger_addr,
  input  logic [RAM_ADDR_BITS-1:0] stop_addr,
  input  logic                     read_req_first,
  input  logic                     read_req_next,
  output logic                     ram_rd_en,
  output logic [RAM_ADDR_BITS-1:0] ram_rd_addr,
  input  logic [NR_SIGNALS-1:0]    ram_rd_data,
  output logic [NR_SIGNALS-1:0]    read_data,
  output logic                     read_valid,
  output logic                     read_last,
  output logic                     read_done,
  output logic                     read_err,
  output logic [RAM_ADDR_BITS-1:0] read_idx,
  output logic [1:0]               dbg_state
`ifdef ICETAP_READ_TRIG_MARK_EN
  ,
  output logic                     read_is_trig
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } fsm_t;

  localparam logic [1:0] REC_DONE = 2'd3;
  localparam logic [1:0] LAT_LOAD = 2'(RAM_LATENCY - 1);
  localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = RAM_ADDR_BITS'(1);

  fsm_t                     state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [RAM_ADDR_BITS-1:0] idx_q, idx_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [NR_SIGNALS-1:0]    data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     last_q, last_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     trig_q, trig_d;
  logic [RAM_ADDR_BITS-1:0] first_addr;
  logic                     rec_done;
  logic                     trig_hit;

  // Oldest sample: after a wrap it sits just past the last written address.
  assign first_addr = wrapped ? (stop_addr + ADDR_ONE) : start_addr;
  assign rec_done   = (state == REC_DONE);

`ifdef ICETAP_READ_TRIG_MARK_EN
  assign trig_hit = (addr_q == trigger_addr);
`else
  logic unused_trigger_addr;
  assign unused_trigger_addr = ^trigger_addr;
  assign trig_hit = 1'b0;
`endif

  // Handshake: read_req_first/read_req_next are single-cycle pulses with no
  // backpressure; read_valid holds one sample until a request consumes it.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    trig_d  = trig_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (state_q == S_IDLE) begin
      if (read_req_first) begin
        if (rec_done) begin
          addr_d  = first_addr;
          idx_d   = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
          trig_d  = 1'b0;
          state_d = S_ISSUE;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (!rec_done) begin
      // Recorder re-armed under us: the RAM contents are no longer this capture.
      err_d   = 1'b1;
      valid_d = 1'b0;
      last_d  = 1'b0;
      trig_d  = 1'b0;
      state_d = S_IDLE;
    end else if (read_req_first) begin
      addr_d  = first_addr;
      idx_d   = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      trig_d  = 1'b0;
      state_d = S_ISSUE;
    end else begin
      case (state_q)
        S_ISSUE: begin
          cnt_d   = LAT_LOAD;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == 2'd0) begin
            data_d  = ram_rd_data;
            valid_d = 1'b1;
            last_d  = (addr_q == stop_addr);
            trig_d  = trig_hit;
            state_d = S_HOLD;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        S_HOLD: begin
          if (read_req_next) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            trig_d  = 1'b0;
            if (last_q) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              addr_d  = addr_q + ADDR_ONE;
              idx_d   = idx_q + ADDR_ONE;
              state_d = S_ISSUE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge src_clk) begin
    if (src_reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
      trig_q  <= trig_d;
    end
  end

  assign ram_rd_en   = (state_q == S_ISSUE);
  assign ram_rd_addr = addr_q;
  assign read_data   = data_q;
  assign read_valid  = valid_q;
  assign read_last   = last_q;
  assign read_done   = done_q;
  assign read_err    = err_q;
  assign read_idx    = idx_q;
  assign dbg_state   = state_q;

`ifdef ICETAP_READ_TRIG_MARK_EN
  assign read_is_trig = trig_q;
`else
  logic unused_trig_q;
  assign unused_trig_q = trig_q;
`endif

endmodule

// File: tb/tb_icetap_read_ctrl.sv
// Self-checking bench for icetap_read_ctrl: table-driven captures, hand-written corner sequences,
// and randomized captures against a queue-based readout model with a latency-pipelined RAM.
module tb_icetap_read_ctrl;

  localparam int W     = 16;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int LAT   = 2;

  logic          src_clk;
  logic          src_reset;
  logic [1:0]    state;
  logic          wrapped;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] trigger_addr;
  logic [AW-1:0] stop_addr;
  logic          read_req_first;
  logic          read_req_next;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [W-1:0]  ram_rd_data;
  logic [W-1:0]  read_data;
  logic          read_valid;
  logic          read_last;
  logic          read_done;
  logic          read_err;
  logic [AW-1:0] read_idx;
  logic [1:0]    dbg_state;
`ifdef ICETAP_READ_TRIG_MARK_EN
  logic          read_is_trig;
`endif

  icetap_read_ctrl #(
    .NR_SIGNALS  (W),
    .RECORD_DEPTH(DEPTH),
    .RAM_LATENCY (LAT)
  ) dut (
    .src_clk       (src_clk),
    .src_reset     (src_reset),
    .state         (state),
    .wrapped       (wrapped),
    .start_addr    (start_addr),
    .trigger_addr  (trigger_addr),
    .stop_addr     (stop_addr),
    .read_req_first(read_req_first),
    .read_req_next (read_req_next),
    .ram_rd_en     (ram_rd_en),
    .ram_rd_addr   (ram_rd_addr),
    .ram_rd_data   (ram_rd_data),
    .read_data     (read_data),
    .read_valid    (read_valid),
    .read_last     (read_last),
    .read_done     (read_done),
    .read_err      (read_err),
    .read_idx      (read_idx),
    .dbg_state     (dbg_state)
`ifdef ICETAP_READ_TRIG_MARK_EN
    ,
    .read_is_trig  (read_is_trig)
`endif
  );

  // ---------------- clock / reset ----------------
  initial src_clk = 1'b0;
  always #5 src_clk = ~src_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model: data appears LAT cycles after the strobe ----------------
  logic [W-1:0] mem  [DEPTH];
  logic [W-1:0] pipe [LAT];

  always @(posedge src_clk) begin
    pipe[0] <= ram_rd_en ? mem[ram_rd_addr] : W'($urandom);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_rd_data = pipe[LAT-1];

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [AW-1:0] exp_addr_q[$];
  logic [W-1:0]  exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Readout order from the capture description: oldest sample first, stop_addr last.
  task automatic model_readout(input logic wr, input logic [AW-1:0] st, input logic [AW-1:0] sp);
    int a;
    exp_addr_q.delete();
    exp_q.delete();
    a = wr ? (int'(sp) + 1) % DEPTH : int'(st);
    for (int n = 0; n < DEPTH; n++) begin
      exp_addr_q.push_back(AW'(a));
      exp_q.push_back(mem[a]);
      if (a == int'(sp)) break;
      a = (a + 1) % DEPTH;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge src_clk);
    #1;
  endtask

  task automatic pulse_first();
    read_req_first = 1'b1;
    step();
    read_req_first = 1'b0;
  endtask

  task automatic pulse_next();
    read_req_next = 1'b1;
    step();
    read_req_next = 1'b0;
  endtask

  task automatic wait_valid(input bit noise, input logic [AW-1:0] exp_addr, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (read_valid) begin
        ok = 1'b1;
        break;
      end
      if (ram_rd_en) check("rd_addr", 32'(ram_rd_addr), 32'(exp_addr));
      read_req_next = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end
    read_req_next = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL valid_timeout: read_valid never rose for addr %0h", exp_addr);
    end
  endtask

  task automatic do_readout(input bit noise, output int n_seen, output logic [AW-1:0] first_seen);
    bit ok;
    int idx;
    int hold_n;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    logic          last;
    n_seen = 0;
    first_seen = '0;
    idx = 0;
    pulse_first();
    while (exp_addr_q.size() > 0) begin
      a = exp_addr_q.pop_front();
      d = exp_q.pop_front();
      last = (exp_addr_q.size() == 0);
      wait_valid(noise, a, ok);
      if (!ok) break;
      if (n_seen == 0) first_seen = ram_rd_addr;
      n_seen++;
      check("data", 32'(read_data), 32'(d));
      check("idx", 32'(read_idx), 32'(idx));
      check("last", 32'(read_last), 32'(last));
`ifdef ICETAP_READ_TRIG_MARK_EN
      check("is_trig", 32'(read_is_trig), 32'(a == trigger_addr));
`endif
      hold_n = noise ? int'($urandom_range(0, 2)) : 0;
      repeat (hold_n) begin
        step();
        check("hold_valid", 32'(read_valid), 32'd1);
        check("hold_data", 32'(read_data), 32'(d));
      end
      pulse_next();
      if (last) begin
        check("done", 32'(read_done), 32'd1);
        check("done_valid_drop", 32'(read_valid), 32'd0);
        step();
        check("done_pulse_width", 32'(read_done), 32'd0);
      end else begin
        check("next_valid_drop", 32'(read_valid), 32'd0);
        check("next_rd_en", 32'(ram_rd_en), 32'd1);
      end
      idx++;
    end
    exp_addr_q.delete();
    exp_q.delete();
  endtask

  task automatic set_capture(input logic wr, input logic [AW-1:0] st, input logic [AW-1:0] sp,
                             input logic [AW-1:0] tr);
    state        = 2'd3;
    wrapped      = wr;
    start_addr   = st;
    stop_addr    = sp;
    trigger_addr = tr;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          wrapped;
    logic [AW-1:0] start;
    logic [AW-1:0] stop;
    logic [AW-1:0] trig;
    int            exp_n;
    logic [AW-1:0] exp_first;
  } vec_t;

  vec_t vecs[4];

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int n_seen;
    int n_exp;
    logic [AW-1:0] first_seen;
    logic [AW-1:0] st;

    vecs[0] = '{wrapped: 1'b0, start: 8'h10, stop: 8'h13, trig: 8'h12, exp_n: 4,   exp_first: 8'h10};
    vecs[1] = '{wrapped: 1'b1, start: 8'h00, stop: 8'hFE, trig: 8'h80, exp_n: 256, exp_first: 8'hFF};
    vecs[2] = '{wrapped: 1'b0, start: 8'h40, stop: 8'h40, trig: 8'h40, exp_n: 1,   exp_first: 8'h40};
    vecs[3] = '{wrapped: 1'b1, start: 8'h33, stop: 8'hFF, trig: 8'h00, exp_n: 256, exp_first: 8'h00};

    for (int i = 0; i < DEPTH; i++) mem[i] = W'($urandom);

    src_reset = 1'b1;
    read_req_first = 1'b0;
    read_req_next  = 1'b0;
    set_capture(1'b0, 8'h10, 8'h13, 8'h12);
    state = 2'd0;
    repeat (3) step();
    src_reset = 1'b0;
    step();

    // reset state
    check("rst_rd_en", 32'(ram_rd_en), 32'd0);
    check("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
    check("rst_valid", 32'(read_valid), 32'd0);
    check("rst_data", 32'(read_data), 32'd0);
    check("rst_idx", 32'(read_idx), 32'd0);
    check("rst_last_done_err", 32'({read_last, read_done, read_err}), 32'd0);

    // request while recorder still armed: rejected
    state = 2'd1;
    pulse_first();
    check("armed_err", 32'(read_err), 32'd1);
    check("armed_no_rd_en", 32'(ram_rd_en), 32'd0);
    step();
    check("armed_err_width", 32'(read_err), 32'd0);
    check("armed_still_idle", 32'(ram_rd_en), 32'd0);

    // exact latency with a 2-cycle RAM
    set_capture(1'b0, 8'h10, 8'h13, 8'h12);
    pulse_first();
    check("lat_t1_rd_en", 32'(ram_rd_en), 32'd1);
    check("lat_t1_addr", 32'(ram_rd_addr), 32'h10);
    step();
    check("lat_t2_rd_en", 32'(ram_rd_en), 32'd0);
    check("lat_t2_valid", 32'(read_valid), 32'd0);
    step();
    check("lat_t3_valid", 32'(read_valid), 32'd0);
    step();
    check("lat_t4_valid", 32'(read_valid), 32'd1);
    check("lat_t4_data", 32'(read_data), 32'(mem[8'h10]));

    // table-driven captures
    for (int v = 0; v < 4; v++) begin
      set_capture(vecs[v].wrapped, vecs[v].start, vecs[v].stop, vecs[v].trig);
      model_readout(vecs[v].wrapped, vecs[v].start, vecs[v].stop);
      do_readout(1'b0, n_seen, first_seen);
      check($sformatf("vec%0d_count", v), 32'(n_seen), 32'(vecs[v].exp_n));
      check($sformatf("vec%0d_first", v), 32'(first_seen), 32'(vecs[v].exp_first));
    end

    // first and next together in HOLD: restart wins
    set_capture(1'b0, 8'h10, 8'h13, 8'h12);
    pulse_first();
    wait_valid(1'b0, 8'h10, ok);
    pulse_next();
    wait_valid(1'b0, 8'h11, ok);
    check("both_pre_idx", 32'(read_idx), 32'd1);
    read_req_first = 1'b1;
    read_req_next  = 1'b1;
    step();
    read_req_first = 1'b0;
    read_req_next  = 1'b0;
    check("both_rd_en", 32'(ram_rd_en), 32'd1);
    check("both_addr", 32'(ram_rd_addr), 32'h10);
    check("both_valid_drop", 32'(read_valid), 32'd0);
    wait_valid(1'b0, 8'h10, ok);
    check("both_idx", 32'(read_idx), 32'd0);
    check("both_data", 32'(read_data), 32'(mem[8'h10]));

    // recorder leaves DONE while holding a sample: abort
    state = 2'd0;
    step();
    check("abort_err", 32'(read_err), 32'd1);
    check("abort_valid", 32'(read_valid), 32'd0);
    state = 2'd3;
    step();
    check("abort_err_width", 32'(read_err), 32'd0);
    pulse_next();
    check("abort_next_ignored", 32'(ram_rd_en), 32'd0);
    check("abort_idle_valid", 32'(read_valid), 32'd0);

    // reset while waiting on the RAM: everything clears, no error
    set_capture(1'b0, 8'h10, 8'h13, 8'h12);
    pulse_first();
    wait_valid(1'b0, 8'h10, ok);
    pulse_next();
    wait_valid(1'b0, 8'h11, ok);
    pulse_next();
    step();
    src_reset = 1'b1;
    step();
    check("rstw_rd_en", 32'(ram_rd_en), 32'd0);
    check("rstw_addr", 32'(ram_rd_addr), 32'd0);
    check("rstw_data", 32'(read_data), 32'd0);
    check("rstw_valid", 32'(read_valid), 32'd0);
    check("rstw_idx", 32'(read_idx), 32'd0);
    check("rstw_flags", 32'({read_last, read_done, read_err}), 32'd0);
`ifdef ICETAP_READ_TRIG_MARK_EN
    check("rstw_trig", 32'(read_is_trig), 32'd0);
`endif
    src_reset = 1'b0;
    step();
    check("rstw_after_err", 32'(read_err), 32'd0);

    // randomized captures against the model
    for (int r = 0; r < 20; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        set_capture(1'b1, AW'($urandom), AW'($urandom), AW'($urandom));
      end else begin
        st = AW'($urandom_range(0, DEPTH - 1));
        set_capture(1'b0, st, AW'($urandom_range(int'(st), DEPTH - 1)), AW'($urandom));
        if ($urandom_range(0, 1) == 1)
          trigger_addr = AW'($urandom_range(int'(start_addr), int'(stop_addr)));
      end
      model_readout(wrapped, start_addr, stop_addr);
      n_exp = exp_addr_q.size();
      do_readout(1'b1, n_seen, first_seen);
      check($sformatf("rand%0d_count", r), 32'(n_seen), 32'(n_exp));
      check($sformatf("rand%0d_idle", r), 32'(read_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
